// File: rtl/shifter_pkg.sv
// Shared types and constants for the pipelined barrel shifter.
// Imported by the stage sub-module and the top.
package shifter_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    SHIFT_SLL = 2'd0,
    SHIFT_SRL = 2'd1,
    SHIFT_SRA = 2'd2,
    SHIFT_ROR = 2'd3
  } shift_op_t;

endpackage

// File: rtl/shift_stage.sv
// One logarithmic shifter stage: shifts by the constant AMT when i_en is set,
// otherwise passes the operand through untouched.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int N   = 32,
  parameter int AMT = 1
) (
  input  logic [N-1:0] i_data,
  input  shift_op_t    i_op,
  input  logic         i_en,
  output logic [N-1:0] o_data
);

  logic [N-1:0] w_shifted;

  // SRA fills from the MSB of this stage's input, which carries the original sign forward.
  always_comb begin
    w_shifted = i_data;
    case (i_op)
      SHIFT_SLL: w_shifted = i_data << AMT;
      SHIFT_SRL: w_shifted = i_data >> AMT;
      SHIFT_SRA: w_shifted = N'($signed(i_data) >>> AMT);
      SHIFT_ROR: w_shifted = (i_data >> AMT) | (i_data << (N - AMT));
      default:   w_shifted = i_data;
    endcase
  end

  assign o_data = i_en ? w_shifted : i_data;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, with a
// single global advance signal so the whole pipe either moves or holds.
module barrel_shifter_pipe
  import shifter_pkg::*;
#(
  parameter int N     = 32,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic [$clog2(N)-1:0] in_shamt,
  input  logic [OP_W-1:0]      in_op,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int S = $clog2(N);

  logic             w_adv;
  logic [S-1:0]     w_validIn;
  logic [N-1:0]     w_dataIn  [S];
  logic [N-1:0]     w_dataOut [S];
  shift_op_t        w_opIn    [S];
  logic [S-1:0]     w_shamtIn [S];
  logic [TAG_W-1:0] w_tagIn   [S];
  logic             w_unusedShamt;

  logic [S-1:0]     r_valid;
  logic [N-1:0]     r_data  [S];
  logic [TAG_W-1:0] r_tag   [S];
  shift_op_t        r_op    [S-1];
  logic [S-1:0]     r_shamt [S-1];

  assign w_adv     = ~r_valid[S-1] | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_valid[S-1];
  assign out_data  = r_valid[S-1] ? r_data[S-1] : '0;
  assign out_tag   = r_valid[S-1] ? r_tag[S-1]  : '0;
  assign w_validIn = {r_valid[S-2:0], in_valid};

  // The shift amount is shifted right each stage, so bit 0 is always the live enable.
  assign w_unusedShamt = ^w_shamtIn[S-1][S-1:1];

  for (genvar k = 0; k < S; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_dataIn[k]  = in_data;
      assign w_opIn[k]    = shift_op_t'(in_op);
      assign w_shamtIn[k] = in_shamt;
      assign w_tagIn[k]   = in_tag;
    end else begin : g_body
      assign w_dataIn[k]  = r_data[k-1];
      assign w_opIn[k]    = r_op[k-1];
      assign w_shamtIn[k] = r_shamt[k-1];
      assign w_tagIn[k]   = r_tag[k-1];
    end

    shift_stage #(
      .N   (N),
      .AMT (2 ** k)
    ) u_shift (
      .i_data (w_dataIn[k]),
      .i_op   (w_opIn[k]),
      .i_en   (w_shamtIn[k][0]),
      .o_data (w_dataOut[k])
    );
  end

  // Bubbles move with the pipe too, so a stall anywhere freezes every stage together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int k = 0; k < S; k++) begin
        r_data[k] <= '0;
        r_tag[k]  <= '0;
      end
      for (int k = 0; k < S - 1; k++) begin
        r_op[k]    <= SHIFT_SLL;
        r_shamt[k] <= '0;
      end
    end else if (w_adv) begin
      r_valid <= w_validIn;
      for (int k = 0; k < S; k++) begin
        r_data[k] <= w_dataOut[k];
        r_tag[k]  <= w_tagIn[k];
      end
      for (int k = 0; k < S - 1; k++) begin
        r_op[k]    <= w_opIn[k];
        r_shamt[k] <= w_shamtIn[k] >> 1;
      end
    end
  end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe (N=32, TAG_W=4): directed vectors,
// throughput, back-pressure, mid-flight reset and a long randomized run.
module tb_barrel_shifter_pipe;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic [1:0]  in_op = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_tag;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tag;
  } exp_t;

  exp_t expQ[$];
  int   nAssert = 0;
  int   nFail = 0;

  always #5 clk = ~clk;

  barrel_shifter_pipe #(.N(32), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  // Reference written as arithmetic: shifts as multiply/divide by 2**sh, SRA as
  // floor division of a signed value, ROR as a window into the doubled word.
  function automatic logic [31:0] refShift(input logic [1:0] op, input int sh,
                                           input logic [31:0] d);
    logic [63:0] dbl;
    logic [31:0] pow;
    pow = 32'd1 << sh;
    dbl = {d, d} >> sh;
    case (op)
      2'd0:    return d * pow;
      2'd1:    return d / pow;
      2'd2:    return d[31] ? ~((~d) / pow) : d / pow;
      default: return dbl[31:0];
    endcase
  endfunction

  // Drive one cycle of inputs at the falling edge and sample the handshake just after.
  task automatic step(input logic v, input logic [1:0] op, input logic [4:0] sh,
                      input logic [31:0] d, input logic [3:0] tg, input logic ordy,
                      output logic acc, output logic xfer, output logic ov,
                      output logic ir, output logic [31:0] od, output logic [3:0] ot);
    @(negedge clk);
    in_valid  = v;
    in_op     = op;
    in_shamt  = sh;
    in_data   = d;
    in_tag    = tg;
    out_ready = ordy;
    #1;
    ov   = out_valid;
    ir   = in_ready;
    od   = out_data;
    ot   = out_tag;
    acc  = in_valid & in_ready;
    xfer = out_valid & out_ready;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    nAssert++;
    if ({out_valid, out_data, out_tag} !== 37'd0) begin
      nFail++;
      $display("[TB] FAIL reset_outputs: got v=%b d=%h t=%h expected all zero",
               out_valid, out_data, out_tag);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    nAssert++;
    if (in_ready !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  vOp [6] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd2, 2'd3};
    logic [4:0]  vSh [6] = '{5'd31, 5'd4, 5'd4, 5'd1, 5'd0, 5'd0};
    logic [31:0] vD  [6] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000,
                             32'h0000_0001, 32'h8000_0001, 32'hDEAD_BEEF};
    logic [3:0]  vTg [6] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    logic [31:0] vEx [6] = '{32'h8000_0000, 32'hF800_0000, 32'h0800_0000,
                             32'h8000_0000, 32'h8000_0001, 32'hDEAD_BEEF};
    logic acc, xfer, ov, ir;
    logic [31:0] od;
    logic [3:0]  ot;
    int lat;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, vOp[i], vSh[i], vD[i], vTg[i], 1'b1, acc, xfer, ov, ir, od, ot);
      lat = -1;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
        step(1'b0, 2'd0, 5'd0, 32'd0, 4'd0, 1'b1, acc, xfer, ov, ir, od, ot);
        if (xfer) lat = c;
      end
      nAssert++;
      if (lat != LAT) begin
        nFail++;
        $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, LAT);
      end
      nAssert++;
      if ({od, ot} !== {vEx[i], vTg[i]}) begin
        nFail++;
        $display("[TB] FAIL directed_result[%0d]: got %h/%h expected %h/%h",
                 i, od, ot, vEx[i], vTg[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic acc, xfer, ov, ir;
    logic [31:0] od, d;
    logic [3:0]  ot, tg;
    logic [1:0]  op;
    logic [4:0]  sh;
    int firstX = -1, lastX = -1, got = 0;
    exp_t e;
    for (int c = 0; c < 60; c++) begin
      op = 2'($urandom_range(0, 3));
      sh = 5'($urandom_range(0, 31));
      d  = $urandom;
      tg = 4'(c);
      step(c < 32, op, sh, d, tg, 1'b1, acc, xfer, ov, ir, od, ot);
      if (xfer) begin
        if (firstX < 0) firstX = c;
        lastX = c;
        got++;
        e = expQ.pop_front();
        nAssert++;
        if ({od, ot} !== {e.data, e.tag}) begin
          nFail++;
          $display("[TB] FAIL b2b_result: got %h/%h expected %h/%h", od, ot, e.data, e.tag);
        end
      end
      if (acc) expQ.push_back({refShift(op, int'(sh), d), tg});
    end
    nAssert++;
    if (got != 32 || firstX != LAT || lastX != LAT + 31) begin
      nFail++;
      $display("[TB] FAIL b2b_throughput: got count=%0d first=%0d last=%0d expected 32/%0d/%0d",
               got, firstX, lastX, LAT, LAT + 31);
    end
  endtask

  task automatic test_stall();
    logic acc, xfer, ov, ir;
    logic [31:0] od, d;
    logic [3:0]  ot;
    logic [1:0]  op;
    logic [4:0]  sh;
    int got = 0;
    exp_t e;
    for (int i = 0; i < LAT; i++) begin
      op = 2'($urandom_range(0, 3));
      sh = 5'($urandom_range(0, 31));
      d  = $urandom;
      step(1'b1, op, sh, d, 4'(i + 10), 1'b0, acc, xfer, ov, ir, od, ot);
      nAssert++;
      if (acc !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL stall_fill_accept[%0d]: got %b expected 1", i, acc);
      end
      if (acc) expQ.push_back({refShift(op, int'(sh), d), 4'(i + 10)});
    end
    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      step(1'b0, 2'd0, 5'd0, 32'd0, 4'd0, 1'b0, acc, xfer, ov, ir, od, ot);
      nAssert++;
      if ({ov, ir, od, ot} !== {1'b1, 1'b0, expQ[0].data, expQ[0].tag}) begin
        nFail++;
        $display("[TB] FAIL stall_hold[%0d]: got v=%b rdy=%b %h/%h expected v=1 rdy=0 %h/%h",
                 i, ov, ir, od, ot, expQ[0].data, expQ[0].tag);
      end
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 2'd0, 5'd0, 32'd0, 4'd0, 1'b1, acc, xfer, ov, ir, od, ot);
      if (xfer) begin
        got++;
        if (expQ.size() == 0) begin
          nAssert++;
          nFail++;
          $display("[TB] FAIL stall_extra: got %h/%h expected no result", od, ot);
        end else begin
          e = expQ.pop_front();
          nAssert++;
          if ({od, ot} !== {e.data, e.tag}) begin
            nFail++;
            $display("[TB] FAIL stall_drain: got %h/%h expected %h/%h", od, ot, e.data, e.tag);
          end
        end
      end
    end
    nAssert++;
    if (got != LAT) begin
      nFail++;
      $display("[TB] FAIL stall_count: got %0d expected %0d", got, LAT);
    end
  endtask

  task automatic test_reset_midflight();
    logic acc, xfer, ov, ir;
    logic [31:0] od;
    logic [3:0]  ot;
    int stale = 0;
    for (int i = 0; i < 3; i++)
      step(1'b1, 2'd0, 5'd1, $urandom, 4'(i + 1), 1'b1, acc, xfer, ov, ir, od, ot);
    for (int i = 0; i < 2; i++)
      step(1'b0, 2'd0, 5'd0, 32'd0, 4'd0, 1'b1, acc, xfer, ov, ir, od, ot);
    @(negedge clk);
    #1;
    nAssert++;
    if (out_valid !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL midreset_inflight: got out_valid=%b expected 1", out_valid);
    end
    rst = 1'b1;
    #1;
    nAssert++;
    if ({out_valid, out_data, out_tag} !== 37'd0) begin
      nFail++;
      $display("[TB] FAIL midreset_clear: got v=%b d=%h t=%h expected all zero",
               out_valid, out_data, out_tag);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    nAssert++;
    if (in_ready !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL midreset_ready: got %b expected 1", in_ready);
    end
    expQ.delete();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'd0, 5'd0, 32'd0, 4'd0, 1'b1, acc, xfer, ov, ir, od, ot);
      if (ov) stale++;
    end
    nAssert++;
    if (stale != 0) begin
      nFail++;
      $display("[TB] FAIL midreset_stale: got %0d results expected 0", stale);
    end
  endtask

  task automatic test_random();
    logic acc, xfer, ov, ir, pend = 1'b0, ordy;
    logic [31:0] od, d = '0;
    logic [3:0]  ot, tg = '0;
    logic [1:0]  op = '0;
    logic [4:0]  sh = '0;
    int sent = 0, got = 0, cyc = 0;
    exp_t e;
    while (got < 10000 && cyc < 60000) begin
      if (!pend && sent < 10000 && $urandom_range(0, 9) < 8) begin
        op   = 2'($urandom_range(0, 3));
        sh   = 5'($urandom_range(0, 31));
        d    = $urandom;
        tg   = 4'($urandom_range(0, 15));
        pend = 1'b1;
      end
      ordy = ($urandom_range(0, 9) < 7);
      step(pend, op, sh, d, tg, ordy, acc, xfer, ov, ir, od, ot);
      cyc++;
      if (xfer) begin
        got++;
        if (expQ.size() == 0) begin
          nAssert++;
          nFail++;
          $display("[TB] FAIL random_extra: got %h/%h expected no result", od, ot);
        end else begin
          e = expQ.pop_front();
          nAssert++;
          if ({od, ot} !== {e.data, e.tag}) begin
            nFail++;
            $display("[TB] FAIL random_result[%0d]: got %h/%h expected %h/%h",
                     got, od, ot, e.data, e.tag);
          end
        end
      end else if (!ov) begin
        nAssert++;
        if ({od, ot} !== 36'd0) begin
          nFail++;
          $display("[TB] FAIL random_idle_zero: got %h/%h expected 0/0", od, ot);
        end
      end
      if (acc) begin
        expQ.push_back({refShift(op, int'(sh), d), tg});
        pend = 1'b0;
        sent++;
      end
    end
    nAssert++;
    if (got != 10000 || expQ.size() != 0) begin
      nFail++;
      $display("[TB] FAIL random_complete: got %0d results (%0d pending) expected 10000 (0)",
               got, expQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
